// File: rtl/alfa_pkg.sv
// Shared types and constants for the note key encoder: FSM states, note codes,
// and the priority pick used when several keys are down at once.
package alfa_pkg;

  localparam int NUM_KEYS = 7;
  localparam int NOTA_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [NOTA_W-1:0] NOTA_C = 3'd0;
  localparam logic [NOTA_W-1:0] NOTA_D = 3'd1;
  localparam logic [NOTA_W-1:0] NOTA_E = 3'd2;
  localparam logic [NOTA_W-1:0] NOTA_F = 3'd3;
  localparam logic [NOTA_W-1:0] NOTA_G = 3'd4;
  localparam logic [NOTA_W-1:0] NOTA_A = 3'd5;
  localparam logic [NOTA_W-1:0] NOTA_B = 3'd6;

  // Lowest set bit wins, so C has the highest priority; all-zero maps to C.
  function automatic logic [NOTA_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [NOTA_W-1:0] code;
    code = NOTA_C;
    casez (v)
      7'b??????1: code = NOTA_C;
      7'b?????10: code = NOTA_D;
      7'b????100: code = NOTA_E;
      7'b???1000: code = NOTA_F;
      7'b??10000: code = NOTA_G;
      7'b?100000: code = NOTA_A;
      7'b1000000: code = NOTA_B;
      default:    code = NOTA_C;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous button inputs; two cycles of latency,
// cleared to zero by the asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/note_key_encoder.sv
// Debounced note-key encoder: latches one note code and sharp flag per press,
// pulses valido once on acceptance and holds ativo until the key is released.
module note_key_encoder
  import alfa_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] teclas,
  input  logic                sustenido,
  output logic [NOTA_W-1:0]   notas,
  output logic                tom,
  output logic                valido,
  output logic                ativo
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("note_key_encoder: DEBOUNCE_CYCLES must be within 1..65535");
  end

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS:0]   w_sync_in;
  logic [NUM_KEYS:0]   w_sync_out;
  logic [NUM_KEYS-1:0] w_ks;
  logic                w_ss;
  logic                w_cand_hi;

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [NOTA_W-1:0]   r_cand;
  logic [NOTA_W-1:0]   r_notas;
  logic                r_tom;
  logic                r_valido;
  logic                r_ativo;

  state_t              w_state_nxt;
  logic [15:0]         w_cnt_nxt;
  logic [NOTA_W-1:0]   w_cand_nxt;
  logic [NOTA_W-1:0]   w_notas_nxt;
  logic                w_tom_nxt;
  logic                w_valido_nxt;
  logic                w_ativo_nxt;

  assign w_sync_in = {sustenido, teclas};

  sync_2ff #(
    .WIDTH (NUM_KEYS + 1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_sync_in),
    .o_q   (w_sync_out)
  );

  assign w_ks = w_sync_out[NUM_KEYS-1:0];
  assign w_ss = w_sync_out[NUM_KEYS];

  // Only the candidate key matters once one is chosen; all other keys are ignored.
  assign w_cand_hi = |(w_ks & (NUM_KEYS'(1) << r_cand));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cand_nxt   = r_cand;
    w_notas_nxt  = r_notas;
    w_tom_nxt    = r_tom;
    w_valido_nxt = 1'b0;
    w_ativo_nxt  = r_ativo;

    unique case (r_state)
      ST_IDLE: begin
        if (|w_ks) begin
          w_cand_nxt  = lowest_set(w_ks);
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_cand_hi) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_HELD;
          w_notas_nxt  = r_cand;
          w_tom_nxt    = w_ss;
          w_valido_nxt = 1'b1;
          w_ativo_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_HELD: begin
        if (!w_cand_hi) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // A return to high here is release bounce: resume HELD silently.
        if (w_cand_hi) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_ativo_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cand   <= '0;
      r_notas  <= '0;
      r_tom    <= 1'b0;
      r_valido <= 1'b0;
      r_ativo  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cand   <= w_cand_nxt;
      r_notas  <= w_notas_nxt;
      r_tom    <= w_tom_nxt;
      r_valido <= w_valido_nxt;
      r_ativo  <= w_ativo_nxt;
    end
  end

  assign notas  = r_notas;
  assign tom    = r_tom;
  assign valido = r_valido;
  assign ativo  = r_ativo;

endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder with DEBOUNCE_CYCLES=4: directed scenarios then
// random key/sharp activity, all checked every cycle against a run-length model.
module tb_note_key_encoder;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] teclas;
  logic       sustenido;
  logic [2:0] notas;
  logic       tom;
  logic       valido;
  logic       ativo;

  note_key_encoder #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .teclas    (teclas),
    .sustenido (sustenido),
    .notas     (notas),
    .tom       (tom),
    .valido    (valido),
    .ativo     (ativo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  // Reference model: inputs reach the decision logic two edges after sampling;
  // a key is accepted after D+1 consecutive high observations, released after
  // D+1 consecutive low observations.
  logic [7:0] hist[$];
  int         cand;
  int         hi_run;
  int         lo_run;
  bit         accepted;
  int         m_notas;
  int         m_tom;
  int         m_valido;
  int         m_ativo;

  int  edges;
  int  v_count;
  int  last_v_edge;
  int  fall_edge;
  bit  prev_ativo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    hist.push_back(8'h00);
    cand     = -1;
    hi_run   = 0;
    lo_run   = 0;
    accepted = 1'b0;
    m_notas  = 0;
    m_tom    = 0;
    m_valido = 0;
    m_ativo  = 0;
  endtask

  task automatic model_edge();
    logic [7:0] seen;
    logic [6:0] ks;
    seen = hist.pop_front();
    hist.push_back({sustenido, teclas});
    ks = seen[6:0];
    m_valido = 0;
    if (cand < 0) begin
      if (ks != 7'd0) begin
        for (int i = 6; i >= 0; i--) if (ks[i]) cand = i;
        hi_run = 1;
      end
    end else if (!accepted) begin
      if (!ks[cand]) begin
        cand = -1;
      end else begin
        hi_run++;
        if (hi_run == D + 1) begin
          accepted = 1'b1;
          lo_run   = 0;
          m_notas  = cand;
          m_tom    = seen[7];
          m_valido = 1;
          m_ativo  = 1;
        end
      end
    end else begin
      if (ks[cand]) begin
        lo_run = 0;
      end else begin
        lo_run++;
        if (lo_run == D + 1) begin
          accepted = 1'b0;
          cand     = -1;
          m_ativo  = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("notas",  32'(notas),  32'(m_notas));
    check("tom",    32'(tom),    32'(m_tom));
    check("valido", 32'(valido), 32'(m_valido));
    check("ativo",  32'(ativo),  32'(m_ativo));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      edges++;
      #1;
      check_outputs();
      if (valido === 1'b1) begin
        v_count++;
        last_v_edge = edges;
      end
      if (prev_ativo && ativo === 1'b0) fall_edge = edges;
      prev_ativo = (ativo === 1'b1);
    end
  endtask

  task automatic pulse_reset_check();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_async_zero", {notas, tom, valido, ativo}, 32'd0);
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int e0;
    int hold;
    edges       = 0;
    v_count     = 0;
    last_v_edge = -1;
    fall_edge   = -1;
    prev_ativo  = 1'b0;
    rst_n       = 1'b0;
    teclas      = 7'd0;
    sustenido   = 1'b0;
    model_reset();
    #3;
    check("reset_state", {notas, tom, valido, ativo}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);

    // Clean press of E, 20 cycles held.
    v_count = 0;
    e0 = edges;
    teclas = 7'b0000100;
    step(20);
    check("E_valido_count", v_count, 1);
    check("E_press_latency", last_v_edge - (e0 + 1), D + 2);
    check("E_notas", notas, 2);
    e0 = edges;
    teclas = 7'd0;
    step(12);
    check("E_release_latency", fall_edge - (e0 + 1), D + 2);
    check("E_notas_kept", notas, 2);

    // C and G together with sharp, then C released while G stays down.
    v_count = 0;
    teclas = 7'b0010001;
    sustenido = 1'b1;
    step(15);
    check("CG_valido_count", v_count, 1);
    check("CG_tom", tom, 1);
    teclas = 7'b0010000;
    step(25);
    check("G_valido_count", v_count, 2);
    check("G_notas", notas, 4);
    check("G_after_fall", last_v_edge - fall_edge, D + 1);
    teclas = 7'd0;
    sustenido = 1'b0;
    step(12);

    // Press bounce on A.
    v_count = 0;
    teclas = 7'b0100000;
    step(2);
    teclas = 7'd0;
    step(1);
    teclas = 7'b0100000;
    step(15);
    check("A_bounce_valido", v_count, 1);
    check("A_notas", notas, 5);
    teclas = 7'd0;
    step(12);

    // Release bounce on D.
    v_count = 0;
    teclas = 7'b0000010;
    step(12);
    teclas = 7'd0;
    step(2);
    teclas = 7'b0000010;
    step(8);
    check("D_rel_bounce_ativo", ativo, 1);
    check("D_rel_bounce_valido", v_count, 1);
    e0 = edges;
    teclas = 7'd0;
    step(12);
    check("D_final_release", fall_edge - (e0 + 1), D + 2);

    // Sharp toggling while F is held.
    v_count = 0;
    teclas = 7'b0001000;
    step(10);
    for (int i = 0; i < 8; i++) begin
      sustenido = ~sustenido;
      step(1);
    end
    check("F_tom_kept", tom, 0);
    check("F_valido_count", v_count, 1);
    teclas = 7'd0;
    sustenido = 1'b0;
    step(12);

    // Reset mid-DEBOUNCE, then mid-HELD, with B held throughout.
    teclas = 7'b1000000;
    step(4);
    pulse_reset_check();
    v_count = 0;
    e0 = edges;
    step(10);
    check("B_post_reset_latency", last_v_edge - (e0 + 1), D + 2);
    pulse_reset_check();
    v_count = 0;
    e0 = edges;
    step(10);
    check("B_post_reset2_latency", last_v_edge - (e0 + 1), D + 2);
    check("B_post_reset2_count", v_count, 1);
    teclas = 7'd0;
    step(12);

    // Random key/sharp activity.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) teclas = 7'd0;
      else                           teclas = 7'($urandom_range(0, 127));
      sustenido = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      step(hold);
    end
    teclas = 7'd0;
    step(15);
    check("final_idle_ativo", ativo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/note_key_encoder.md
Name: note_key_encoder

Overview:
- Encoder for the note-display path: scans 7 raw note pushbuttons plus a sharp button, and produces the registered note code and sharp flag consumed by the 7-segment note decoder.
- Raw buttons are synchronised and debounced. Exactly one note is latched per press, and a one-cycle valid strobe is issued.
- Sits between the board push-button pins and the display/decoder stage.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release.
  - Legal range 1..65535.
  - Elaboration error outside that range.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- teclas  input  7  raw note buttons, active high.
  - Bit i = note code i, in order C=0, D=1, E=2, F=3, G=4, A=5, B=6.
- sustenido  input  1  raw sharp button, active high
- notas  output  3  latched note code 0..6; notas[2] drives decoder input notas3
- tom  output  1  latched sharp flag (decoder input Tom)
- valido  output  1  one-cycle pulse when a new press is accepted
- ativo  output  1  high while the accepted key is considered held

Behaviour:
- Reset (async assert, sync deassert):
  - notas=0, tom=0, valido=0, ativo=0.
  - FSM=IDLE, counter=0, candidate=0, synchronisers cleared.
  - Assertion mid-operation discards any press in progress immediately.
- Synchronisation: teclas and sustenido each pass through a 2-FF synchroniser. All FSM decisions use the synchronised values (ks, ss).
- Counter: 16 bits. Cleared on every state entry.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - If any ks bit is high: candidate = lowest set index (priority C highest), counter=0, go to DEBOUNCE.
- DEBOUNCE:
  - If ks[candidate] is low, return to IDLE. No outputs change.
  - Else if counter == DEBOUNCE_CYCLES-1: go to HELD; register notas=candidate, tom=ss, valido=1 (single cycle), ativo=1.
  - Else increment the counter.
  - Other keys changing during DEBOUNCE are ignored.
- HELD:
  - Stay while ks[candidate] is high.
  - Other keys pressed or released are ignored: no rollover, no new valido.
  - sustenido changes are ignored; tom keeps its value sampled at acceptance.
  - When ks[candidate] goes low: go to RELEASE, counter=0.
- RELEASE:
  - If ks[candidate] goes high again: return to HELD. This is a bounce; no valido is issued and ativo stays 1.
  - Else if counter == DEBOUNCE_CYCLES-1: go to IDLE, ativo=0.
  - Else increment the counter.
- notas and tom hold their last accepted value after release until the next acceptance. The display keeps showing the last note.
- valido is high for exactly one cycle per accepted press and is never high in two consecutive cycles.
- Latency, with stable inputs:
  - Press: first edge sampling the raw key high, then valido and ativo are high after DEBOUNCE_CYCLES+2 further edges.
  - Release: first edge sampling the raw key low, then ativo is low after DEBOUNCE_CYCLES+2 further edges.
- Simultaneous keys: the lowest index wins in IDLE. A key released and another pressed in the same cycle while HELD goes RELEASE → IDLE, then the new key is accepted normally.
- DEBOUNCE_CYCLES=1: a press is accepted on the first DEBOUNCE cycle.

Decomposition:
- Package alfa_pkg:
  - state enum (IDLE, DEBOUNCE, HELD, RELEASE)
  - NUM_KEYS=7, NOTA_W=3
  - note code constants NOTA_C..NOTA_B (0..6)
  - a lowest-set-bit priority function
- Sub-module sync_2ff, parameterised width (8 here: 7 keys + sharp), async active-low reset to 0.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Clean press of teclas[2] (E) held 20 cycles, sustenido=0 → valido pulses once, 6 edges after the first sampling edge; notas=2, tom=0, ativo=1. After release, ativo=0 6 edges later; notas stays 2.
- teclas[0] and teclas[4] rise together with sustenido=1 → notas=0, tom=1, single valido.
  - Then teclas[0] is released while teclas[4] stays held → no valido until ativo drops. G is then accepted: notas=4, second valido.
- Bounce on press: teclas[5] high 2 cycles, low 1, high steady → no valido from the glitch. Exactly one valido with notas=5.
- Bounce on release: held key drops for 2 cycles then returns → ativo stays 1, no new valido. Final release drops ativo after 6 edges.
- Sharp change while HELD: sustenido toggles during the hold → tom stays at its acceptance value and no valido is issued.
- rst_n pulsed low mid-DEBOUNCE and again mid-HELD → all outputs 0 immediately (async). After rst_n is released with the key still held, a fresh valido appears 6 edges after the first post-reset sampling edge.
